// File: rtl/cache_mem_responder.sv
// Memory-side burst responder behind the L1 data cache: programmable-latency line refill and write-back.
// Optional macro RESP_ERR_CHECK_EN adds mem_err_o and rejects misaligned or out-of-range requests.
module cache_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_cs_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_data_i,
    output logic [31:0]           mem_data_o,
    output logic                  mem_ack_o,
    output logic                  mem_busy_o
`ifdef RESP_ERR_CHECK_EN
    ,
    output logic                  mem_err_o
`endif
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = IDX_W - OFF_W;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [OFF_W-1:0]  beat;
    logic [OFF_W-1:0]  beat_next;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] line_next;
    logic              we;
    logic              we_next;
    logic              ack_next;
    logic              busy_next;
    logic              load_data;
    logic              req_err;
    logic              wr_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       mem [MEM_WORDS];

    // Beat counter lives in the low index bits, so bursts wrap inside the line
    assign rd_idx = {line, beat_next};
    assign wr_idx = {line, beat};
    assign wr_en  = (state == BURST) && we && !req_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            beat       <= '0;
            line       <= '0;
            we         <= 1'b0;
            mem_ack_o  <= 1'b0;
            mem_busy_o <= 1'b0;
            mem_data_o <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            beat       <= beat_next;
            line       <= line_next;
            we         <= we_next;
            mem_ack_o  <= ack_next;
            mem_busy_o <= busy_next;
            if (load_data) begin
                mem_data_o <= req_err ? 32'h0 : mem[rd_idx];
            end
        end
    end

    // The array is deliberately not reset so an aborted burst keeps what it already wrote
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= mem_data_i;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        beat_next  = beat;
        line_next  = line;
        we_next    = we;
        ack_next   = 1'b0;
        busy_next  = mem_busy_o;
        load_data  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_cs_i) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                    line_next  = mem_addr_i[IDX_W+1:OFF_W+2];
                    we_next    = mem_we_i;
                    busy_next  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = BURST;
                    beat_next  = '0;
                    ack_next   = 1'b1;
                    load_data  = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            BURST: begin
                // An error response is a single beat; a normal burst runs the whole line
                if (beat == LAST_BEAT || req_err) begin
                    state_next = DONE;
                end else begin
                    beat_next = beat + 1'b1;
                    ack_next  = 1'b1;
                    load_data = 1'b1;
                end
            end
            DONE: begin
                if (!mem_cs_i) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

`ifdef RESP_ERR_CHECK_EN
    logic addr_bad;

    assign addr_bad = (mem_addr_i[OFF_W+1:0] != '0) ||
                      (mem_addr_i[ADDR_WIDTH-1:IDX_W+2] != '0);

    // Error status is captured with the request and reported only on its single ack beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_err   <= 1'b0;
            mem_err_o <= 1'b0;
        end else begin
            if (state == IDLE && mem_cs_i) begin
                req_err <= addr_bad;
            end
            mem_err_o <= ack_next && req_err;
        end
    end
`else
    logic unused_addr;

    assign req_err     = 1'b0;
    assign unused_addr = ^{mem_addr_i[ADDR_WIDTH-1:IDX_W+2], mem_addr_i[OFF_W+1:0]};
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: reference word array predicts refill data and ack timing.
module tb_cache_mem_responder;

    localparam int MEM_WORDS  = 1024;
    localparam int LINE_WORDS = 4;
    localparam int LATENCY    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_busy;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [MEM_WORDS];
    logic [31:0] wbuf  [LINE_WORDS];
    logic [31:0] exp_q [$];

    cache_mem_responder #(
        .ADDR_WIDTH(32),
        .MEM_WORDS (MEM_WORDS),
        .LINE_WORDS(LINE_WORDS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_cs_i  (mem_cs),
        .mem_we_i  (mem_we),
        .mem_addr_i(mem_addr),
        .mem_data_i(mem_wdata),
        .mem_data_o(mem_rdata),
        .mem_ack_o (mem_ack),
        .mem_busy_o(mem_busy)
`ifdef RESP_ERR_CHECK_EN
        ,
        .mem_err_o (mem_err)
`endif
    );

`ifndef RESP_ERR_CHECK_EN
    assign mem_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // Initiator: drives one line burst, pushes predicted read data and checks each beat as it arrives
    task automatic burst(input logic we, input logic [31:0] addr, input int abort_after);
        logic [31:0] base;
        logic [31:0] exp;
        int n;
        int waitc;
        base = (addr >> 2) & 32'(MEM_WORDS - 1);
        base = base & ~32'(LINE_WORDS - 1);
        if (!we) begin
            for (int k = 0; k < LINE_WORDS; k++) exp_q.push_back(model[base + 32'(k)]);
        end
        mem_cs    = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wbuf[0];
        @(posedge clk); #1;
        checks++;
        if (mem_busy !== 1'b1 || mem_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept addr=%h: busy=%b ack=%b, required busy=1 ack=0", addr, mem_busy, mem_ack);
        end
        mem_addr = ~addr;
        mem_we   = ~we;
        n = 0;
        waitc = 0;
        while (n < LINE_WORDS && waitc < 40) begin
            @(posedge clk); #1;
            waitc++;
            if (mem_ack === 1'b1) begin
                checks++;
                if (waitc != LATENCY + n) begin
                    errors++;
                    $display("[TB] FAIL ack_timing beat %0d: at cycle %0d, required cycle %0d", n, waitc, LATENCY + n);
                end
                if (we) begin
                    mem_wdata = wbuf[n];
                    model[base + 32'(n)] = wbuf[n];
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (mem_rdata !== exp) begin
                        errors++;
                        $display("[TB] FAIL read_data addr=%h beat %0d: got %h, required %h", addr, n, mem_rdata, exp);
                    end
                end
`ifdef RESP_ERR_CHECK_EN
                checks++;
                if (mem_err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL err_on_normal beat %0d: got %b, required 0", n, mem_err);
                end
`endif
                n++;
                if (n == abort_after) begin
                    @(posedge clk); #1;
                    rst = 1'b0;
                    #1;
                    checks++;
                    if (mem_ack !== 1'b0 || mem_busy !== 1'b0 || mem_rdata !== 32'h0) begin
                        errors++;
                        $display("[TB] FAIL abort_clear: ack=%b busy=%b data=%h, required 0 0 00000000", mem_ack, mem_busy, mem_rdata);
                    end
                    mem_cs = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b1;
                    return;
                end
            end
        end
        if (n < LINE_WORDS) begin
            checks++;
            errors++;
            $display("[TB] FAIL burst_timeout addr=%h: %0d beats, required %0d", addr, n, LINE_WORDS);
            exp_q.delete();
        end
        @(posedge clk); #1;
        checks++;
        if (mem_ack !== 1'b0 || mem_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_state: ack=%b busy=%b, required ack=0 busy=1", mem_ack, mem_busy);
        end
        mem_cs = 1'b0;
    endtask

    task automatic idle_gap();
        @(posedge clk); #1;
        checks++;
        if (mem_busy !== 1'b0 || mem_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_gap: busy=%b ack=%b, required 0 0", mem_busy, mem_ack);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < LINE_WORDS; k++) wbuf[k] = $urandom;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_ack !== 1'b0 || mem_busy !== 1'b0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ack=%b busy=%b data=%h, required 0 0 00000000", mem_ack, mem_busy, mem_rdata);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_ack !== 1'b0 || mem_busy !== 1'b0 || mem_rdata !== 32'h0) begin
                errors++;
                $display("[TB] FAIL idle_hold cycle %0d: ack=%b busy=%b data=%h, required 0 0 00000000", i, mem_ack, mem_busy, mem_rdata);
            end
        end
    endtask

    task automatic test_write_refill();
        wbuf[0] = 32'h78901234;
        wbuf[1] = 32'h89012345;
        wbuf[2] = 32'h12345678;
        wbuf[3] = 32'h23456789;
        burst(1'b1, 32'h200, 0);
        idle_gap();
        burst(1'b0, 32'h200, 0);
        idle_gap();
    endtask

    task automatic test_back_to_back();
        fill_random();
        burst(1'b1, 32'h60, 0);
        idle_gap();
        fill_random();
        burst(1'b1, 32'h160, 0);
        idle_gap();
        burst(1'b0, 32'h60, 0);
        idle_gap();
        burst(1'b0, 32'h160, 0);
        idle_gap();
    endtask

    task automatic test_wrap();
`ifndef RESP_ERR_CHECK_EN
        fill_random();
        burst(1'b1, 32'h10, 0);
        idle_gap();
        burst(1'b0, 32'h10 + 32'(MEM_WORDS * 4), 0);
        idle_gap();
        burst(1'b0, 32'h14, 0);
        idle_gap();
`endif
    endtask

    task automatic test_reset_mid_burst();
        fill_random();
        burst(1'b1, 32'h400, 0);
        idle_gap();
        fill_random();
        burst(1'b1, 32'h400, 2);
        burst(1'b0, 32'h400, 0);
        idle_gap();
    endtask

    task automatic test_err_check();
`ifdef RESP_ERR_CHECK_EN
        int waitc;
        fill_random();
        burst(1'b1, 32'h0, 0);
        idle_gap();
        mem_cs   = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h4;
        @(posedge clk); #1;
        checks++;
        if (mem_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_accept: busy=%b, required 1", mem_busy);
        end
        waitc = 0;
        while (mem_ack !== 1'b1 && waitc < 40) begin
            @(posedge clk); #1;
            waitc++;
        end
        checks++;
        if (waitc != LATENCY || mem_err !== 1'b1 || mem_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL err_beat: cycle=%0d err=%b data=%h, required cycle %0d err=1 data=00000000", waitc, mem_err, mem_rdata, LATENCY);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_ack !== 1'b0 || mem_err !== 1'b0 || mem_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_done: ack=%b err=%b busy=%b, required 0 0 1", mem_ack, mem_err, mem_busy);
        end
        mem_cs = 1'b0;
        idle_gap();
        burst(1'b0, 32'h0, 0);
        idle_gap();
`endif
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_write_refill();
        test_back_to_back();
        test_wrap();
        test_reset_mid_burst();
        test_err_check();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
